pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; power of two, 8..64.
REQ-002 SHALL have localparam LEVELS = log2(WIDTH), the number of shift levels and pipeline stages (5 at WIDTH=32).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  in  1  operand valid.
REQ-006 SHALL have port in_ready  out  1  operand accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port dataA  in  WIDTH  value to shift.
REQ-008 SHALL have port dataB  in  WIDTH  shift amount, full width, unsigned.
REQ-009 SHALL have port mode  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 SHALL have port out_valid  out  1  dataOut holds a result.
REQ-011 SHALL have port out_ready  in  1  consumer takes the result when out_valid && out_ready at a rising edge.
REQ-012 SHALL have port dataOut  out  WIDTH  result.
REQ-013 SHALL have port busy  out  1  high while any pipeline stage holds a valid entry.

Function
REQ-014 SHALL implement LEVELS registered stages; stage i applies a shift of 2^i when amount bit i is set, so one mux level per stage.
REQ-015 SHALL carry mode, a valid bit, an out-of-range flag and the dataA sign bit alongside the data in every stage.
REQ-016 SHALL assert out_valid with the final result exactly LEVELS-1 edges after the accepting edge when there is no stall (accept at edge 0 gives a result at edge 4 for WIDTH=32).
REQ-017 SHALL sustain one operation per cycle; results leave in acceptance order.
REQ-018 SHALL advance the whole pipeline when adv = !(out_valid && !out_ready); when adv is low every stage SHALL hold its contents.
REQ-019 SHALL drive in_ready = adv combinationally; the pipeline does not squeeze out bubbles.
REQ-020 SHALL hold dataOut and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL fill SLL and SRL with zeros and fill SRA with the dataA sign bit.
REQ-022 SHALL set the out-of-range flag when dataB >= WIDTH; the result is then 0 for SLL and SRL, and all-ones or zero (the sign replicated) for SRA.
REQ-023 SHALL rotate right by dataB mod WIDTH for ROR and ignore the out-of-range flag.
REQ-024 SHALL return dataA unchanged for an amount of 0 in every mode.
REQ-025 SHALL accept a new input and retire the head result on the same edge when in_valid, out_valid and out_ready are all high.
REQ-026 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-027 SHALL, while reset is high, clear all stage valid bits and data registers immediately, force out_valid=0, dataOut=0 and busy=0, and keep in_ready=1.
REQ-028 SHALL discard in-flight operations when reset is asserted mid-operation; no stale result may appear after reset releases.
REQ-029 SHALL accept an operand on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL gate rotate support with the macro PIPE_SHIFTER_ROTATE_EN.
REQ-031 SHALL, with PIPE_SHIFTER_ROTATE_EN defined, implement mode 11 as ROR per REQ-023.
REQ-032 SHALL, without PIPE_SHIFTER_ROTATE_EN, execute mode 11 exactly as SRL (01), including the out-of-range rule, and contain no wrap-around mux logic.

Verification (WIDTH=32)
REQ-033 SHALL cover: SRL dataA=0x80000000, dataB=31 -> dataOut=0x00000001, out_valid 4 edges after accept.
REQ-034 SHALL cover: SRA 0x80000000 by 4 -> 0xF8000000; SRA 0x80000001 by 33 -> 0xFFFFFFFF; SLL 0x12345678 by 40 -> 0x00000000.
REQ-035 SHALL cover: mode 11 with 0x00000001 by 33 -> 0x80000000 with the macro defined; -> 0x00000000 without it.
REQ-036 SHALL cover: 6 back-to-back ops with out_ready low -> in_ready falls after the pipe fills, no loss, and results appear in order once out_ready=1.
REQ-037 SHALL cover: reset pulsed with 3 ops in flight -> out_valid=0 and busy=0 immediately; no result appears within 8 cycles after release.
REQ-038 SHALL cover: a random 10k-op SLL/SRL/SRA/ROR stream with random out_ready -> bit-exact match with a reference model.

Source files
------------

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter: one shift level per registered stage with a valid/ready handshake.
// Define PIPE_SHIFTER_ROTATE_EN to make mode 11 a rotate right; without it mode 11 behaves as SRL.
module pipe_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy
);
    localparam int LEVELS = $clog2(WIDTH);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    logic              adv;
    logic [1:0]        mode_eff;
    logic              out_of_range;
    logic [LEVELS-1:0] valid_vec;
    logic              last_force;
    logic              last_fill;

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0]       m,
                                                    input logic             sign,
                                                    input int               s);
        logic [WIDTH-1:0] fill;
        fill = ~({WIDTH{1'b1}} >> s);
        case (m)
            MODE_SLL: return d << s;
            MODE_SRA: return (d >> s) | (sign ? fill : '0);
`ifdef PIPE_SHIFTER_ROTATE_EN
            MODE_ROR: return (d >> s) | (d << (WIDTH - s));
`endif
            default:  return d >> s;
        endcase
    endfunction

`ifdef PIPE_SHIFTER_ROTATE_EN
    assign mode_eff = mode;
`else
    // Without rotate support mode 11 is folded onto SRL at the entry, so no wrap path exists.
    assign mode_eff = (mode == MODE_ROR) ? MODE_SRL : mode;
`endif

    assign out_of_range = |dataB[WIDTH-1:LEVELS];
    assign adv          = !(out_valid && !out_ready);
    assign in_ready     = adv;
    assign busy         = |valid_vec;

    for (genvar i = 0; i < LEVELS; i++) begin : g_stage
        logic [WIDTH-1:0] d_in, d_q;
        logic [1:0]       m_in, m_q;
        logic             v_in, v_q, o_in, o_q, s_in, s_q, a_bit;

        if (i == 0) begin : g_head
            assign d_in  = dataA;
            assign m_in  = mode_eff;
            assign v_in  = in_valid;
            assign o_in  = out_of_range;
            assign s_in  = dataA[WIDTH-1];
            assign a_bit = dataB[0];
        end else begin : g_link
            assign d_in  = g_stage[i-1].d_q;
            assign m_in  = g_stage[i-1].m_q;
            assign v_in  = g_stage[i-1].v_q;
            assign o_in  = g_stage[i-1].o_q;
            assign s_in  = g_stage[i-1].s_q;
            assign a_bit = g_stage[i-1].g_amt.amt_q[0];
        end

        // Each stage keeps only the amount bits still to be consumed further down the pipe.
        if (i < LEVELS - 1) begin : g_amt
            logic [LEVELS-2-i:0] amt_in, amt_q;
            if (i == 0) begin : g_first
                assign amt_in = dataB[LEVELS-1:1];
            end else begin : g_next
                assign amt_in = g_stage[i-1].g_amt.amt_q[LEVELS-1-i:1];
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    amt_q <= '0;
                end else if (adv) begin
                    amt_q <= amt_in;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                d_q <= '0;
                m_q <= MODE_SLL;
                v_q <= 1'b0;
                o_q <= 1'b0;
                s_q <= 1'b0;
            end else if (adv) begin
                d_q <= a_bit ? shift_step(d_in, m_in, s_in, 1 << i) : d_in;
                m_q <= m_in;
                v_q <= v_in;
                o_q <= o_in;
                s_q <= s_in;
            end
        end

        assign valid_vec[i] = v_q;
    end

    // Out-of-range shifts collapse to the fill value; rotate ignores the range flag.
    assign last_force = g_stage[LEVELS-1].o_q && (g_stage[LEVELS-1].m_q != MODE_ROR);
    assign last_fill  = g_stage[LEVELS-1].s_q && (g_stage[LEVELS-1].m_q == MODE_SRA);
    assign out_valid  = g_stage[LEVELS-1].v_q;
    assign dataOut    = last_force ? {WIDTH{last_fill}} : g_stage[LEVELS-1].d_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter at WIDTH=32: directed vectors plus a scoreboarded random stream.
// Honours PIPE_SHIFTER_ROTATE_EN the same way the design does.
module tb_pipe_shifter;
    localparam int WIDTH  = 32;
    localparam int LEVELS = 5;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  dataA     = '0;
    logic [WIDTH-1:0]  dataB     = '0;
    logic [1:0]        mode      = 2'b00;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  dataOut;
    logic              busy;

    int compared    = 0;
    int mismatched  = 0;
    int advCount    = 0;
    int acceptCount = 0;
    int retireCount = 0;

    typedef struct {
        logic [31:0] value;
        int          stamp;
    } entry_t;
    entry_t q[$];

`ifdef PIPE_SHIFTER_ROTATE_EN
    localparam logic [31:0] EXP_ROR33 = 32'h80000000;
    localparam logic [31:0] EXP_ROR4  = 32'h81234567;
`else
    localparam logic [31:0] EXP_ROR33 = 32'h00000000;
    localparam logic [31:0] EXP_ROR4  = 32'h01234567;
`endif

    logic [1:0]  vecM [15] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd0, 2'd2, 2'd0,
                               2'd1, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] vecA [15] = '{32'h80000000, 32'h80000000, 32'h80000001, 32'h12345678,
                               32'h00000001, 32'h12345678, 32'h7FFFFFFF, 32'h00000001,
                               32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0000000F,
                               32'h0000000F, 32'hABCDEF01, 32'h40000000};
    logic [31:0] vecB [15] = '{32'd31, 32'd4, 32'd33, 32'd40, 32'd33, 32'd0, 32'd32, 32'd31,
                               32'd32, 32'd4, 32'd31, 32'd0, 32'd5, 32'd8, 32'd30};
    logic [31:0] vecE [15] = '{32'h00000001, 32'hF8000000, 32'hFFFFFFFF, 32'h00000000,
                               EXP_ROR33,    32'h12345678, 32'h00000000, 32'h80000000,
                               32'h00000000, EXP_ROR4,     32'hFFFFFFFF, 32'h0000000F,
                               32'h000001E0, 32'h00ABCDEF, 32'h00000001};

    pipe_shifter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataA     (dataA),
        .dataB     (dataB),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataOut   (dataOut),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] m);
        logic signed [31:0] sa;
        logic [1:0]         op;
        op = m;
`ifdef PIPE_SHIFTER_ROTATE_EN
        if (op == 2'b11) begin
            logic [63:0] twice;
            twice = {a, a} >> (b % 32);
            return twice[31:0];
        end
`else
        if (op == 2'b11) op = 2'b01;
`endif
        if (b >= 32) return (op == 2'b10 && a[31]) ? 32'hFFFFFFFF : 32'h00000000;
        sa = a;
        case (op)
            2'b00:   return a << b;
            2'b01:   return a >> b;
            default: return 32'(sa >>> b);
        endcase
    endfunction

    function automatic logic modelValid();
        return (q.size() != 0) && ((advCount - q[0].stamp) >= LEVELS - 1);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: an entry sits in the pipe until it has seen LEVELS-1 advancing edges.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
        end else begin
            logic mv, madv;
            mv   = modelValid();
            madv = !(mv && !out_ready);
            if (mv && out_ready) begin
                void'(q.pop_front());
                retireCount++;
            end
            if (madv) advCount++;
            if (in_valid && madv) begin
                q.push_back('{expModel(dataA, dataB, mode), advCount});
                acceptCount++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            checkOutput("rst_out_valid", out_valid, 1'b0);
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_in_ready", in_ready, 1'b1);
            checkOutput("rst_dataOut", dataOut, 32'h0);
        end else begin
            checkOutput("out_valid", out_valid, modelValid());
            checkOutput("in_ready", in_ready, !(modelValid() && !out_ready));
            checkOutput("busy", busy, q.size() != 0);
            if (modelValid()) checkOutput("dataOut", dataOut, q[0].value);
        end
    end

    // Single isolated operation; also measures edges from acceptance to out_valid.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] m, input logic [31:0] expected);
        int n;
        checkOutput("model_pin", expModel(a, b, m), expected);
        out_ready = 1'b1;
        dataA     = a;
        dataB     = b;
        mode      = m;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        checkOutput("latency", n, LEVELS - 1);
        checkOutput("directed_result", dataOut, expected);
        @(posedge clk);
        #1;
    endtask

    task automatic pushOp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        int guard;
        guard    = 0;
        dataA    = a;
        dataB    = b;
        mode     = m;
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1 guard++;
        end
        if (guard >= 50) checkOutput("push_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1 guard++;
        end
        @(posedge clk);
        #1 checkOutput("drain_busy", busy, 1'b0);
    endtask

    initial begin
        int r0, target, cyc;

        #2;
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_dataOut", dataOut, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // First op is offered on the very first edge after reset release.
        for (int i = 0; i < 15; i++) applyStimulus(vecA[i], vecB[i], vecM[i], vecE[i]);

        $display("[TB] backpressure with out_ready low");
        r0        = retireCount;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) pushOp(32'h11110000 + k, k, 2'(k % 3));
        dataA    = 32'h11110005;
        dataB    = 32'd5;
        mode     = 2'd2;
        in_valid = 1'b1;
        #1 checkOutput("bp_in_ready_low", in_ready, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", out_valid, 1'b1);
            checkOutput("bp_hold_data", dataOut, 32'h11110000);
            checkOutput("bp_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        pushOp(32'h11110005, 32'd5, 2'd2);
        drain();
        checkOutput("bp_retired", retireCount - r0, 6);

        $display("[TB] reset with ops in flight");
        pushOp(32'hF0F0F0F0, 32'd3, 2'd1);
        pushOp(32'h0000FFFF, 32'd8, 2'd0);
        pushOp(32'h80000000, 32'd2, 2'd2);
        checkOutput("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_out_valid", out_valid, 1'b0);
        checkOutput("mid_reset_busy", busy, 1'b0);
        checkOutput("mid_reset_dataOut", dataOut, 32'h0);
        checkOutput("mid_reset_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 checkOutput("post_reset_quiet", out_valid, 1'b0);
        end

        $display("[TB] random stream");
        target = acceptCount + 10000;
        cyc    = 0;
        while (acceptCount < target && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            dataA     = $urandom;
            mode      = 2'($urandom_range(0, 3));
            dataB     = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1 cyc++;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
